cpkt_unpack: RTL and testbench

- Consumer stage directly downstream of the cell-packet mux.
- Drains the mux's two FWFT FIFOs: an info FIFO holding one channel ID per packet, and a cell FIFO holding CELLSZ cells per packet.
- Reassembles each packet into one wide word tagged with its channel ID.
- Presents the result on a valid/ready interface to the TCP RX per-connection logic.

---
 rtl/cpkt_unpack_if.sv | 30 +++
 rtl/cpkt_unpack.sv | 137 +++++++++++++
 tb/tb_cpkt_unpack.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cpkt_unpack_if.sv
// Bundle between the cell-packet mux FIFOs, the unpacker and the TCP RX consumer.
// master = unpacker side (drives pops, output word and debug); slave = environment side.
interface cpkt_unpack_if #(
    parameter int ID_WID  = 7,
    parameter int DWID    = 12,
    parameter int CELLSZ  = 4,
    parameter int DBG_WID = 32
);
    logic                     in_info_ren;
    logic [ID_WID-1:0]        in_info_rdata;
    logic                     in_info_nempty;
    logic                     in_cpkt_ren;
    logic [DWID-1:0]          in_cpkt_rdata;
    logic                     in_cpkt_nempty;
    logic                     out_vld;
    logic [ID_WID-1:0]        out_id;
    logic [DWID*CELLSZ-1:0]   out_data;
    logic                     out_rdy;
    logic [DBG_WID-1:0]       dbg_sig;

    modport master (
        output in_info_ren, in_cpkt_ren, out_vld, out_id, out_data, dbg_sig,
        input  in_info_rdata, in_info_nempty, in_cpkt_rdata, in_cpkt_nempty, out_rdy
    );

    modport slave (
        input  in_info_ren, in_cpkt_ren, out_vld, out_id, out_data, dbg_sig,
        output in_info_rdata, in_info_nempty, in_cpkt_rdata, in_cpkt_nempty, out_rdy
    );
endinterface

// File: rtl/cpkt_unpack.sv
// Pops one ID then CELLSZ cells from FWFT FIFOs and emits them as one tagged wide word.
// Latency: out_vld one cycle after the last cell pop; out_rdy=0 holds the word and stops all pops.
module cpkt_unpack #(
    parameter int UNUM    = 128,
    parameter int ID_WID  = 7,
    parameter int CELLSZ  = 4,
    parameter int DWID    = 12,
    parameter int DBG_WID = 32
) (
    input  logic          clk,
    input  logic          rst,
    cpkt_unpack_if.master bus
);
    localparam int CW = (CELLSZ > 1) ? $clog2(CELLSZ) : 1;
    localparam int PW = DWID * CELLSZ;

    if (2**ID_WID < UNUM) begin : g_bad_id_wid
        $error("ID_WID too narrow for UNUM");
    end
    if (CELLSZ < 1 || CELLSZ > 16) begin : g_bad_cellsz
        $error("CELLSZ out of range 1..16");
    end
    if (DBG_WID < 24) begin : g_bad_dbg_wid
        $error("DBG_WID must be at least 24");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OUT     = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_WID-1:0] id_q;
    logic [CW-1:0]     cell_cnt;
    logic [PW-1:0]     asm_q;
    logic [PW-1:0]     asm_nxt;
    logic              out_vld_q;
    logic [ID_WID-1:0] out_id_q;
    logic [PW-1:0]     out_data_q;
    logic [15:0]       pkt_cnt;
    logic              info_pop;
    logic              cell_pop;
    logic              last_cell;
    logic              hs;
    logic [DBG_WID-1:0] dbg;

    assign last_cell = (cell_cnt == CW'(CELLSZ - 1));
    assign hs        = (state == OUT) & out_vld_q & bus.out_rdy;

    // Strobes are gated by reset so nothing is popped while the FIFOs are being re-aligned.
    always_comb begin
        state_nxt = state;
        info_pop  = 1'b0;
        cell_pop  = 1'b0;
        case (state)
            IDLE: begin
                info_pop = bus.in_info_nempty;
                if (bus.in_info_nempty) state_nxt = COLLECT;
            end
            COLLECT: begin
                cell_pop = bus.in_cpkt_nempty;
                if (bus.in_cpkt_nempty && last_cell) state_nxt = OUT;
            end
            OUT: begin
                if (hs) begin
                    info_pop  = bus.in_info_nempty;
                    state_nxt = bus.in_info_nempty ? COLLECT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        info_pop = info_pop & rst;
        cell_pop = cell_pop & rst;
    end

    always_comb begin
        asm_nxt = asm_q;
        for (int k = 0; k < CELLSZ; k++) begin
            if (cell_cnt == CW'(k)) asm_nxt[k*DWID +: DWID] = bus.in_cpkt_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q       <= '0;
            cell_cnt   <= '0;
            asm_q      <= '0;
            out_vld_q  <= 1'b0;
            out_id_q   <= '0;
            out_data_q <= '0;
            pkt_cnt    <= '0;
        end else begin
            if (info_pop) begin
                id_q     <= bus.in_info_rdata;
                cell_cnt <= '0;
            end
            if (cell_pop) begin
                asm_q <= asm_nxt;
                if (last_cell) begin
                    cell_cnt   <= '0;
                    out_data_q <= asm_nxt;
                    out_id_q   <= id_q;
                    out_vld_q  <= 1'b1;
                end else begin
                    cell_cnt <= cell_cnt + CW'(1);
                end
            end
            if (hs) begin
                out_vld_q <= 1'b0;
                pkt_cnt   <= pkt_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        dbg        = '0;
        dbg[15:0]  = pkt_cnt;
        dbg[17:16] = state;
        dbg[21:18] = 4'(cell_cnt);
        dbg[22]    = out_vld_q & ~bus.out_rdy;
        dbg[23]    = (state == COLLECT) & ~bus.in_cpkt_nempty;
    end

    assign bus.in_info_ren = info_pop;
    assign bus.in_cpkt_ren = cell_pop;
    assign bus.out_vld     = out_vld_q;
    assign bus.out_id      = out_id_q;
    assign bus.out_data    = out_data_q;
    assign bus.dbg_sig     = dbg;
endmodule

// File: tb/tb_cpkt_unpack.sv
// Directed bench for cpkt_unpack: FWFT FIFO models driven from queues, table of packets plus corner sequences.
module tb_cpkt_unpack;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cpkt_unpack_if #(.ID_WID(7), .DWID(12), .CELLSZ(4), .DBG_WID(32)) bus();

    cpkt_unpack #(
        .UNUM(128), .ID_WID(7), .CELLSZ(4), .DWID(12), .DBG_WID(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [6:0]  id;
        logic [11:0] c0, c1, c2, c3;
        logic [47:0] exp_data;
    } vec_t;

    vec_t        vecs [4];
    logic [6:0]  info_q [$];
    logic [11:0] cell_q [$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          edge_no = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive();
        bus.in_info_nempty = (info_q.size() != 0);
        bus.in_info_rdata  = (info_q.size() != 0) ? info_q[0] : 7'h0;
        bus.in_cpkt_nempty = (cell_q.size() != 0);
        bus.in_cpkt_rdata  = (cell_q.size() != 0) ? cell_q[0] : 12'h0;
        #1;
    endtask

    // Called and returning at the falling edge; pops are decided by the strobes seen before the edge.
    task automatic tick();
        bit pi, pc;
        pi = bus.in_info_ren;
        pc = bus.in_cpkt_ren;
        @(posedge clk);
        edge_no++;
        #1;
        if (pi && info_q.size() != 0) void'(info_q.pop_front());
        if (pc && cell_q.size() != 0) void'(cell_q.pop_front());
        drive();
        @(negedge clk);
    endtask

    task automatic wait_vld(input string nm);
        int n = 0;
        while (!bus.out_vld && n < 30) begin
            tick();
            n++;
        end
        check({nm, "_vld_timeout"}, 64'(bus.out_vld), 64'd1);
    endtask

    task automatic push_pkt(input logic [6:0] id, input logic [11:0] c0, input logic [11:0] c1,
                            input logic [11:0] c2, input logic [11:0] c3, input int n);
        logic [11:0] c [4];
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        info_q.push_back(id);
        for (int i = 0; i < n; i++) cell_q.push_back(c[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          e0;
        int          prev_rise;
        logic [6:0]  hold_id;
        logic [47:0] hold_data;
        int          k;

        vecs[0] = '{id: 7'h01, c0: 12'hABC, c1: 12'h123, c2: 12'h000, c3: 12'hFFF, exp_data: 48'hFFF000123ABC};
        vecs[1] = '{id: 7'h02, c0: 12'h001, c1: 12'h002, c2: 12'h003, c3: 12'h004, exp_data: 48'h004003002001};
        vecs[2] = '{id: 7'h03, c0: 12'hFFF, c1: 12'hFFF, c2: 12'hFFF, c3: 12'hFFF, exp_data: 48'hFFFFFFFFFFFF};
        vecs[3] = '{id: 7'h7F, c0: 12'h800, c1: 12'h001, c2: 12'h080, c3: 12'h010, exp_data: 48'h010080001800};

        rst = 1'b0;
        bus.out_rdy = 1'b1;
        @(negedge clk);

        // Reset held with both FIFOs populated
        push_pkt(7'h05, 12'h111, 12'h222, 12'h333, 12'h444, 4);
        drive();
        repeat (3) tick();
        check("rst_info_ren", 64'(bus.in_info_ren), 64'd0);
        check("rst_cpkt_ren", 64'(bus.in_cpkt_ren), 64'd0);
        check("rst_out_vld",  64'(bus.out_vld), 64'd0);
        check("rst_dbg",      64'(bus.dbg_sig), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);

        rst = 1'b1;
        #1;
        check("first_pop_after_rst", 64'(bus.in_info_ren), 64'd1);
        tick();
        e0 = edge_no;
        wait_vld("single");
        check("single_latency", 64'(edge_no - e0), 64'd4);
        check("single_id",      64'(bus.out_id), 64'h05);
        check("single_data",    64'(bus.out_data), 64'h444333222111);
        tick();
        check("single_vld_1cyc", 64'(bus.out_vld), 64'd0);
        check("single_pkt_cnt",  64'(bus.dbg_sig[15:0]), 64'd1);

        // Back-to-back packets from the table
        foreach (vecs[i]) push_pkt(vecs[i].id, vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3, 4);
        drive();
        prev_rise = 0;
        for (int i = 0; i < 4; i++) begin
            wait_vld("b2b");
            if (i > 0) check("b2b_spacing", 64'(edge_no - prev_rise), 64'd5);
            prev_rise = edge_no;
            check("b2b_id",   64'(bus.out_id), 64'(vecs[i].id));
            check("b2b_data", 64'(bus.out_data), 64'(vecs[i].exp_data));
            check("b2b_info_pop_at_hs", 64'(bus.in_info_ren), (i < 3) ? 64'd1 : 64'd0);
            tick();
        end
        check("b2b_vld_low",  64'(bus.out_vld), 64'd0);
        check("b2b_pkt_cnt",  64'(bus.dbg_sig[15:0]), 64'd5);

        // Backpressure with a second packet waiting
        bus.out_rdy = 1'b0;
        push_pkt(7'h2A, 12'h005, 12'h006, 12'h007, 12'h008, 4);
        push_pkt(7'h2B, 12'h009, 12'h00A, 12'h00B, 12'h00C, 4);
        drive();
        wait_vld("bp");
        hold_id   = bus.out_id;
        hold_data = bus.out_data;
        check("bp_id",   64'(hold_id), 64'h2A);
        check("bp_data", 64'(hold_data), 64'h008007006005);
        for (int c = 0; c < 10; c++) begin
            check("bp_id_stable",   64'(bus.out_id), 64'(hold_id));
            check("bp_data_stable", 64'(bus.out_data), 64'(hold_data));
            check("bp_no_info_pop", 64'(bus.in_info_ren), 64'd0);
            check("bp_no_cell_pop", 64'(bus.in_cpkt_ren), 64'd0);
            check("bp_dbg_stall",   64'(bus.dbg_sig[22]), 64'd1);
            tick();
        end
        bus.out_rdy = 1'b1;
        #1;
        check("bp_release_info_pop", 64'(bus.in_info_ren), 64'd1);
        tick();
        check("bp_release_vld_low", 64'(bus.out_vld), 64'd0);
        wait_vld("bp_next");
        check("bp_next_id",   64'(bus.out_id), 64'h2B);
        check("bp_next_data", 64'(bus.out_data), 64'h00C00B00A009);
        tick();

        // Cell starvation after two cells
        push_pkt(7'h33, 12'hA01, 12'hA02, 12'h000, 12'h000, 2);
        drive();
        repeat (6) tick();
        check("starve_state",    64'(bus.dbg_sig[17:16]), 64'd1);
        check("starve_cell_cnt", 64'(bus.dbg_sig[21:18]), 64'd2);
        check("starve_flag",     64'(bus.dbg_sig[23]), 64'd1);
        check("starve_no_pop",   64'(bus.in_cpkt_ren), 64'd0);
        check("starve_vld_low",  64'(bus.out_vld), 64'd0);
        cell_q.push_back(12'hA03);
        cell_q.push_back(12'hA04);
        drive();
        wait_vld("starve");
        check("starve_id",   64'(bus.out_id), 64'h33);
        check("starve_data", 64'(bus.out_data), 64'hA04A03A02A01);
        tick();

        // Reset asserted mid-COLLECT
        push_pkt(7'h44, 12'hB01, 12'hB02, 12'h000, 12'h000, 2);
        drive();
        k = 0;
        while (bus.dbg_sig[21:18] != 4'd2 && k < 20) begin
            tick();
            k++;
        end
        check("rstmid_pre_cnt", 64'(bus.dbg_sig[21:18]), 64'd2);
        rst = 1'b0;
        #1;
        check("rstmid_state",    64'(bus.dbg_sig[17:16]), 64'd0);
        check("rstmid_cell_cnt", 64'(bus.dbg_sig[21:18]), 64'd0);
        check("rstmid_vld",      64'(bus.out_vld), 64'd0);
        check("rstmid_no_pop",   64'({bus.in_info_ren, bus.in_cpkt_ren}), 64'd0);
        check("rstmid_out_data", 64'(bus.out_data), 64'd0);
        info_q.delete();
        cell_q.delete();
        drive();
        repeat (3) begin
            tick();
            check("rstmid_hold_vld", 64'(bus.out_vld), 64'd0);
        end
        rst = 1'b1;
        #1;
        repeat (5) begin
            tick();
            check("rstmid_after_vld", 64'(bus.out_vld), 64'd0);
        end
        check("rstmid_dbg_clear", 64'(bus.dbg_sig), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
